// File: rtl/fsm_mealy_driver_pkg.sv
// Shared codes and table functions for the 4-state Mealy controller and its driver.
// T (next state), O (Mealy output) and hop (shortest-path input) are the only source of these tables.
package fsm_mealy_driver_pkg;

  typedef enum logic [1:0] {S0, S1, S2, S3} state_e;
  typedef enum logic [1:0] {A0, A1, A2, A3} in_e;
  typedef enum logic [2:0] {Y0, Y1, Y2, Y3, Y4} out_e;
  typedef enum logic [1:0] {DRV_IDLE, DRV_STEER, DRV_DONE} drv_e;

  localparam int MAX_HOPS = 2;

  function automatic state_e T(input state_e s, input logic [1:0] a);
    state_e n;
    n = S0;
    case (s)
      S0: case (a) 2'd0: n = S1; 2'd1: n = S1; 2'd2: n = S2; default: n = S2; endcase
      S1: case (a) 2'd0: n = S2; 2'd1: n = S3; 2'd2: n = S0; default: n = S2; endcase
      S2: case (a) 2'd0: n = S0; 2'd1: n = S2; 2'd2: n = S1; default: n = S2; endcase
      default: case (a) 2'd0: n = S0; 2'd1: n = S1; 2'd2: n = S3; default: n = S3; endcase
    endcase
    return n;
  endfunction

  function automatic out_e O(input state_e s, input logic [1:0] a);
    out_e y;
    y = Y0;
    case (s)
      S0: y = Y1;
      S1: case (a) 2'd0: y = Y3; 2'd1: y = Y1; 2'd2: y = Y1; default: y = Y3; endcase
      S2: case (a) 2'd0: y = Y2; 2'd1: y = Y0; 2'd2: y = Y1; default: y = Y4; endcase
      default: case (a) 2'd0: y = Y2; default: y = Y3; endcase
    endcase
    return y;
  endfunction

  // First input on a shortest path cur -> tgt; value is irrelevant when cur == tgt.
  function automatic in_e hop(input state_e cur, input state_e tgt);
    in_e a;
    a = A0;
    case (cur)
      S0: case (tgt) S2: a = A2; default: a = A0; endcase
      S1: case (tgt) S0: a = A2; S3: a = A1; default: a = A0; endcase
      S2: case (tgt) S1, S3: a = A2; default: a = A0; endcase
      default: case (tgt) S1: a = A1; default: a = A0; endcase
    endcase
    return a;
  endfunction

endpackage

// File: rtl/fsm_mealy_driver_model.sv
// Combinational T/O lookup of the controller tables, used for the shadow update and the checker.
module fsm_mealy_model
  import fsm_mealy_driver_pkg::*;
(
  input  logic [1:0] state_i,
  input  logic [1:0] in_i,
  output logic [1:0] next_o,
  output logic [2:0] out_o
);

  always_comb begin
    next_o = T(state_e'(state_i), in_i);
    out_o  = O(state_e'(state_i), in_i);
  end

endmodule

// File: rtl/fsm_mealy_driver.sv
// Steers the Mealy controller to a requested state over the shortest path while shadowing it.
// Optional checker against the controller's out/state ports: define FSM_DRV_CHECK_EN.
module fsm_mealy_driver
  import fsm_mealy_driver_pkg::*;
#(
  parameter logic [1:0] IDLE_IN = 2'b11,
  parameter int         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_target,
  output logic             done,
  output logic [1:0]       done_state,
  output logic [1:0]       drv_in,
  input  logic [2:0]       dut_out,
  input  logic [2:0]       dut_state,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count
);

  drv_e       state_q, state_d;
  state_e     shadow_q, shadow_d;
  state_e     target_q, target_d;
  logic [1:0] drv_in_q, drv_in_d;
  logic [1:0] shadow_nxt;
  logic [2:0] exp_out;

  fsm_mealy_model u_model (
    .state_i (shadow_q),
    .in_i    (drv_in_q),
    .next_o  (shadow_nxt),
    .out_o   (exp_out)
  );

  // The shadow follows the controller on every edge, whatever the driver is doing.
  assign shadow_d = state_e'(shadow_nxt);
  assign drv_in   = drv_in_q;

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    drv_in_d   = drv_in_q;
    req_ready  = 1'b0;
    done       = 1'b0;
    done_state = 2'b00;
    unique case (state_q)
      DRV_IDLE: begin
        req_ready = 1'b1;
        drv_in_d  = IDLE_IN;
        if (req_valid) begin
          target_d = state_e'(req_target);
          if (shadow_d == state_e'(req_target)) begin
            state_d = DRV_DONE;
          end else begin
            state_d  = DRV_STEER;
            drv_in_d = hop(shadow_d, state_e'(req_target));
          end
        end
      end
      DRV_STEER: begin
        if (shadow_d == target_q) begin
          state_d  = DRV_DONE;
          drv_in_d = IDLE_IN;
        end else begin
          drv_in_d = hop(shadow_d, target_q);
        end
      end
      DRV_DONE: begin
        done       = 1'b1;
        done_state = shadow_q;
        drv_in_d   = IDLE_IN;
        state_d    = DRV_IDLE;
      end
      default: begin
        state_d  = DRV_IDLE;
        drv_in_d = IDLE_IN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= DRV_IDLE;
      shadow_q <= S0;
      drv_in_q <= IDLE_IN;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      drv_in_q <= drv_in_d;
    end
  end

  // Target is only read in STEER, after IDLE has loaded it, so it needs no reset.
  always_ff @(posedge clk) begin
    target_q <= target_d;
  end

`ifdef FSM_DRV_CHECK_EN
  logic             mismatch;
  logic             err_flag_q, err_flag_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  assign mismatch = (dut_out != exp_out) || (dut_state != {1'b0, shadow_q});

  always_comb begin
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    if (mismatch) begin
      err_flag_d = 1'b1;
      if (err_count_q != {CNT_W{1'b1}}) begin
        err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;
`else
  logic unused_chk;
  assign unused_chk = ^{exp_out, dut_out, dut_state};
  assign err_flag   = 1'b0;
  assign err_count  = '0;
`endif

endmodule
